// File: rtl/ctl_stim_pkg.sv
// Shared types and constants for the ctl_stim initiator.
// The MISR helpers are only referenced when CTL_STIM_SIG_EN is defined.
package ctl_stim_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_e;

    localparam int          CNT_W     = 8;
    // x^16 + x^12 + x^3 + x + 1, x^16 term implicit
    localparam logic [15:0] MISR_POLY = 16'h100B;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ d;
    endfunction

endpackage

// File: rtl/ctl_stim_fifo.sv
// Transaction FIFO for the ctl_stim initiator; a pop only sees registered
// contents, so an entry pushed this cycle is poppable next cycle.
module ctl_stim_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         CK,
    input  logic         RSTN,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge CK) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/ctl_stim_initiator.sv
// Queued stimulus driver for a sequential controller core: drive inputs, wait
// for a masked output or timeout, capture and report. SIG MISR: CTL_STIM_SIG_EN.
module ctl_stim_initiator
    import ctl_stim_pkg::*;
#(
    parameter int CMD_W = 17,
    parameter int RSP_W = 19,
    parameter int DEPTH = 4,
    parameter int TMO   = 15
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             LD_VALID,
    output logic             LD_READY,
    input  logic [CMD_W-1:0] LD_CMD,
    input  logic [RSP_W-1:0] LD_MASK,
    output logic             CTL_CLR,
    output logic [CMD_W-1:0] CTL_IN,
    input  logic [RSP_W-1:0] CTL_OUT,
    output logic             DONE,
    output logic             DONE_TMO,
    output logic [RSP_W-1:0] CAPTURE,
    output logic             BUSY
`ifdef CTL_STIM_SIG_EN
    ,
    output logic [15:0]      SIG
`endif
);

    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TMO);

    state_e             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_inc;
    logic [RSP_W-1:0]   mask_q, cap_q;
    logic [CMD_W-1:0]   in_q;
    logic               tmo_q;
    logic               hit, tmo_hit;
    logic               pop, push;
    logic               fifo_empty, fifo_full;
    logic [RSP_W+CMD_W-1:0] fifo_rdata;

    assign push = LD_VALID && LD_READY;

    ctl_stim_fifo #(.W(RSP_W+CMD_W), .DEPTH(DEPTH)) u_fifo (
        .CK    (CK),
        .RSTN  (RSTN),
        .push  (push),
        .wdata ({LD_MASK, LD_CMD}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign hit     = |(CTL_OUT & mask_q);
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    assign tmo_hit = (cnt_inc == TMO_C);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            ST_INIT:  state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (hit || tmo_hit) state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                pop       = !fifo_empty;
                state_nxt = fifo_empty ? ST_IDLE : ST_DRIVE;
            end
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state  <= ST_INIT;
            cnt    <= '0;
            mask_q <= '0;
            in_q   <= '0;
            cap_q  <= '0;
            tmo_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop)
                {mask_q, in_q} <= fifo_rdata;
            else if (state == ST_REPORT)
                in_q <= '0;
            if (state == ST_DRIVE)
                cnt <= '0;
            if (state == ST_WAIT) begin
                // A hit wins over a timeout landing in the same cycle.
                if (hit) begin
                    cap_q <= CTL_OUT;
                    tmo_q <= 1'b0;
                end else begin
                    cnt <= cnt_inc;
                    if (tmo_hit) begin
                        cap_q <= CTL_OUT;
                        tmo_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign LD_READY = !fifo_full && (state != ST_INIT);
    assign CTL_CLR  = (state == ST_INIT);
    assign BUSY     = (state != ST_IDLE);
    assign DONE     = (state == ST_REPORT);
    assign DONE_TMO = DONE && tmo_q;
    assign CTL_IN   = in_q;
    assign CAPTURE  = cap_q;

`ifdef CTL_STIM_SIG_EN
    logic [15:0] fold;

    always_comb begin
        fold = '0;
        for (int i = 0; i < RSP_W; i++)
            fold[i[3:0]] = fold[i[3:0]] ^ cap_q[i];
    end

    always_ff @(posedge CK) begin
        if (!RSTN)
            SIG <= MISR_SEED;
        else if (state == ST_REPORT)
            SIG <= misr_step(SIG, fold ^ {15'd0, tmo_q});
    end
`endif

endmodule

// File: tb/tb_ctl_stim_initiator.sv
// Scoreboard bench for ctl_stim_initiator with a behavioural controller whose
// response appears a command-dependent number of cycles after CTL_IN changes.
module tb_ctl_stim_initiator;

    localparam int CMD_W = 17;
    localparam int RSP_W = 19;
    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic             CK = 1'b0;
    logic             RSTN = 1'b0;
    logic             LD_VALID = 1'b0;
    logic             LD_READY;
    logic [CMD_W-1:0] LD_CMD = '0;
    logic [RSP_W-1:0] LD_MASK = '0;
    logic             CTL_CLR;
    logic [CMD_W-1:0] CTL_IN;
    logic [RSP_W-1:0] CTL_OUT;
    logic             DONE;
    logic             DONE_TMO;
    logic [RSP_W-1:0] CAPTURE;
    logic             BUSY;
`ifdef CTL_STIM_SIG_EN
    logic [15:0]      SIG;
    logic [15:0]      exp_sig = 16'hFFFF;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [4:0] seq = 5'd1;
    logic [RSP_W:0] sb[$];

    ctl_stim_initiator #(.CMD_W(CMD_W), .RSP_W(RSP_W), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .CK       (CK),
        .RSTN     (RSTN),
        .LD_VALID (LD_VALID),
        .LD_READY (LD_READY),
        .LD_CMD   (LD_CMD),
        .LD_MASK  (LD_MASK),
        .CTL_CLR  (CTL_CLR),
        .CTL_IN   (CTL_IN),
        .CTL_OUT  (CTL_OUT),
        .DONE     (DONE),
        .DONE_TMO (DONE_TMO),
        .CAPTURE  (CAPTURE),
        .BUSY     (BUSY)
`ifdef CTL_STIM_SIG_EN
        ,
        .SIG      (SIG)
`endif
    );

    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    // Controller model: delay field cmd[16:12] (0 means 2 cycles with response 1).
    function automatic int kdel(input logic [CMD_W-1:0] c);
        return (c[16:12] == 5'd0) ? 2 : int'(c[16:12]);
    endfunction

    function automatic logic [RSP_W-1:0] resp(input logic [CMD_W-1:0] c);
        if (c[16:12] == 5'd0) return 19'h00001;
        return ({c[1:0], c} ^ {c, 2'b01}) | 19'h40000;
    endfunction

    logic [CMD_W-1:0] prev_in = '0;
    int age = 0;
    int eff_age;

    always @(posedge CK) begin
        age     <= (CTL_IN != prev_in) ? 0 : ((age < 255) ? age + 1 : age);
        prev_in <= CTL_IN;
    end

    assign eff_age = (CTL_IN != prev_in) ? 0 : age + 1;
    assign CTL_OUT = (eff_age >= kdel(CTL_IN)) ? resp(CTL_IN) : '0;

    // Outcome from the rules: the wait cycle j sees the response once j >= delay.
    function automatic logic [RSP_W:0] model(input logic [CMD_W-1:0] c, input logic [RSP_W-1:0] m);
        int k;
        logic [RSP_W-1:0] r;
        k = kdel(c);
        r = resp(c);
        if (k <= TMO && (r & m) != '0) return {1'b0, r};
        return {1'b1, (k <= TMO) ? r : {RSP_W{1'b0}}};
    endfunction

`ifdef CTL_STIM_SIG_EN
    function automatic logic [15:0] sig_next(input logic [15:0] s, input logic [RSP_W:0] e);
        logic [15:0] d;
        d = 16'(e[15:0]) ^ {13'd0, e[18:16]};
        d[0] = d[0] ^ e[RSP_W];
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ d;
    endfunction
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [RSP_W:0] e;
        forever begin
            @(negedge CK);
            if (DONE === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got DONE=1, expected no pending transaction");
                end else begin
                    e = sb.pop_front();
                    chk("done_tmo", 64'(DONE_TMO), 64'(e[RSP_W]));
                    chk("capture", 64'(CAPTURE), 64'(e[RSP_W-1:0]));
`ifdef CTL_STIM_SIG_EN
                    chk("sig", 64'(SIG), 64'(exp_sig));
                    exp_sig = sig_next(exp_sig, e);
`endif
                end
            end
        end
    endtask

    task automatic rnd_cmd(input int k, output logic [CMD_W-1:0] c);
        seq = (seq == 5'd31) ? 5'd1 : seq + 5'd1;
        c = {5'(k), 7'($urandom), seq};
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [CMD_W-1:0] c, input logic [RSP_W-1:0] m);
        int n = 0;
        while (LD_READY !== 1'b1 && n < 500) begin
            @(negedge CK);
            n++;
        end
        if (LD_READY !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL push_wait: got LD_READY=%b, expected 1 within 500 cycles", LD_READY);
        end else begin
            LD_VALID = 1'b1;
            LD_CMD   = c;
            LD_MASK  = m;
            sb.push_back(model(c, m));
            @(negedge CK);
            LD_VALID = 1'b0;
            acc_cyc  = cyc;
        end
    endtask

    task automatic wait_done_lat(input string name, input int exp_lat);
        int n = 0;
        while (DONE !== 1'b1 && n < 200) begin
            @(negedge CK);
            n++;
        end
        chk(name, 64'(cyc - acc_cyc), 64'(exp_lat));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(sb.size() == 0 && BUSY === 1'b0) && n < 3000) begin
            @(negedge CK);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, expected 0 within 3000 cycles", sb.size());
        end
    endtask

    initial begin
        logic [CMD_W-1:0] c;
        int dones, idle, busy_cnt;
        fork
            monitor();
        join_none

        // Reset held for three cycles
        repeat (3) begin
            @(negedge CK);
            chk("rst_clr", 64'(CTL_CLR), 64'd1);
            chk("rst_ready", 64'(LD_READY), 64'd0);
            chk("rst_busy", 64'(BUSY), 64'd1);
            chk("rst_ctl_in", 64'(CTL_IN), 64'd0);
            chk("rst_done", 64'(DONE), 64'd0);
            chk("rst_capture", 64'(CAPTURE), 64'd0);
        end
        @(posedge CK);
        #1 RSTN = 1'b1;
        @(negedge CK);
        chk("init_clr", 64'(CTL_CLR), 64'd1);
        chk("init_ready", 64'(LD_READY), 64'd0);
        @(negedge CK);
        chk("idle_clr", 64'(CTL_CLR), 64'd0);
        chk("idle_ready", 64'(LD_READY), 64'd1);
        chk("idle_busy", 64'(BUSY), 64'd0);
        chk("idle_ctl_in", 64'(CTL_IN), 64'd0);
`ifdef CTL_STIM_SIG_EN
        chk("sig_seed", 64'(SIG), 64'hFFFF);
`endif

        // Directed hit, earliest-hit latency, timeout, priority, just-late
        push(17'h00005, 19'h00001);
        wait_idle();
        rnd_cmd(1, c);
        push(c, '1);
        wait_done_lat("lat_hit", 3);
        wait_idle();
        rnd_cmd(3, c);
        push(c, '0);
        wait_done_lat("lat_tmo", 2 + TMO);
        wait_idle();
        rnd_cmd(TMO, c);
        push(c, '1);
        wait_done_lat("lat_prio", 2 + TMO);
        wait_idle();
        rnd_cmd(TMO + 1, c);
        push(c, '1);
        wait_idle();

        // Back-to-back with a full FIFO behind a long first transaction
        for (int i = 0; i < 5; i++) begin
            rnd_cmd((i == 0) ? 20 : $urandom_range(1, 6), c);
            push(c, 19'($urandom));
        end
        chk("full_ready", 64'(LD_READY), 64'd0);
        dones = 0;
        idle = 0;
        for (int n = 0; n < 600 && dones < 5; n++) begin
            if (DONE === 1'b1) dones++;
            if (BUSY !== 1'b1) idle++;
            @(negedge CK);
        end
        chk("b2b_dones", 64'(dones), 64'd5);
        chk("b2b_idle_cycles", 64'(idle), 64'd0);
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge CK);
            rnd_cmd($urandom_range(0, 31), c);
            push(c, ($urandom_range(0, 3) == 0) ? '0 : 19'($urandom & $urandom));
        end
        wait_idle();

        // Reset in the middle of a wait with entries still queued
        rnd_cmd(25, c);
        push(c, '0);
        rnd_cmd(2, c);
        push(c, '1);
        rnd_cmd(2, c);
        push(c, '1);
        repeat (6) @(negedge CK);
        RSTN = 1'b0;
        sb.delete();
        @(negedge CK);
        chk("mid_rst_ctl_in", 64'(CTL_IN), 64'd0);
        chk("mid_rst_done", 64'(DONE), 64'd0);
        chk("mid_rst_ready", 64'(LD_READY), 64'd0);
`ifdef CTL_STIM_SIG_EN
        chk("mid_rst_sig", 64'(SIG), 64'hFFFF);
        exp_sig = 16'hFFFF;
`endif
        @(posedge CK);
        #1 RSTN = 1'b1;
        @(negedge CK);
        busy_cnt = 0;
        repeat (20) begin
            @(negedge CK);
            if (BUSY !== 1'b0) busy_cnt++;
        end
        chk("post_rst_busy_cycles", 64'(busy_cnt), 64'd0);
        chk("post_rst_ctl_in", 64'(CTL_IN), 64'd0);

        // Traffic still works after the abort
        rnd_cmd(4, c);
        push(c, '1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
